masked_match_decoder: RTL and testbench

Parametrised, registered pattern decoder. It maps a WIDTH-bit input code to a one-bit result plus a matched-entry index, using a runtime-programmable table of value/mask entries. Mask bits are don't-care positions, as in casez, and the lowest index wins on overlap. Codes that hit no entry return a defined default and are counted, so an incomplete table can never infer a latch or leave the output undriven. It sits between a code source and a consumer, with valid/ready handshakes on both sides and a side-band configuration port.

---
 rtl/masked_match_decoder.sv | 149 ++++++++++++++
 tb/tb_masked_match_decoder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/masked_match_decoder.sv
// Registered value/mask pattern decoder: a programmable table maps a code to
// (hit, idx, y) with lowest-index priority and a saturating miss counter.
module masked_match_decoder #(
    parameter int   WIDTH     = 2,
    parameter int   ENTRIES   = 16,
    parameter int   IDXW      = $clog2(ENTRIES),
    parameter int   CNTW      = 16,
    parameter logic DEFAULT_Y = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [IDXW-1:0]  cfg_idx,
    input  logic             cfg_en,
    input  logic [WIDTH-1:0] cfg_value,
    input  logic [WIDTH-1:0] cfg_mask,
    input  logic             cfg_y,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_hit,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_y,
    input  logic             miss_clr,
    output logic [CNTW-1:0]  miss_count,
    output logic             miss_sat
);

    logic             r_en    [ENTRIES];
    logic [WIDTH-1:0] r_value [ENTRIES];
    logic [WIDTH-1:0] r_mask  [ENTRIES];
    logic             r_y     [ENTRIES];

    logic             r_out_valid;
    logic             r_out_hit;
    logic [IDXW-1:0]  r_out_idx;
    logic             r_out_y;
    logic [CNTW-1:0]  r_miss_count;
    logic             r_miss_sat;

    logic [ENTRIES-1:0] w_match;
    logic               w_hit;
    logic [IDXW-1:0]    w_idx;
    logic               w_y;
    logic               w_accept;
    logic [CNTW-1:0]    w_cnt_nxt;

    assign in_ready   = rst_n & (~r_out_valid | out_ready);
    assign w_accept   = in_valid & in_ready;
    assign out_valid  = r_out_valid;
    assign out_hit    = r_out_hit;
    assign out_idx    = r_out_idx;
    assign out_y      = r_out_y;
    assign miss_count = r_miss_count;
    assign miss_sat   = r_miss_sat;

    // Table storage; indices with no matching entry number are never written.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (!rst_n) begin
                r_en[i]    <= 1'b0;
                r_value[i] <= '0;
                r_mask[i]  <= '0;
                r_y[i]     <= 1'b0;
            end else if (cfg_we && (cfg_idx == IDXW'(i))) begin
                r_en[i]    <= cfg_en;
                r_value[i] <= cfg_value;
                r_mask[i]  <= cfg_mask;
                r_y[i]     <= cfg_y;
            end else begin
                r_en[i]    <= r_en[i];
                r_value[i] <= r_value[i];
                r_mask[i]  <= r_mask[i];
                r_y[i]     <= r_y[i];
            end
        end
    end

    // Per-entry match against the registered table contents.
    always_comb begin
        w_match = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            w_match[i] = r_en[i] & (((in_code ^ r_value[i]) & ~r_mask[i]) == '0);
        end
    end

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        w_y   = DEFAULT_Y;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            w_hit = w_match[i] ? 1'b1        : w_hit;
            w_idx = w_match[i] ? IDXW'(i)    : w_idx;
            w_y   = w_match[i] ? r_y[i]      : w_y;
        end
    end

    // Miss counter next value: clear beats increment, increment stops at all-ones.
    always_comb begin
        w_cnt_nxt = r_miss_count;
        if (miss_clr) begin
            w_cnt_nxt = '0;
        end else if (w_accept && !w_hit && !r_miss_sat) begin
            w_cnt_nxt = r_miss_count + CNTW'(1);
        end else begin
            w_cnt_nxt = r_miss_count;
        end
    end

    // Output register: load on accept, drop valid on a bare consume, else hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_hit   <= 1'b0;
            r_out_idx   <= '0;
            r_out_y     <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_hit   <= w_hit;
            r_out_idx   <= w_idx;
            r_out_y     <= w_y;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_hit   <= r_out_hit;
            r_out_idx   <= r_out_idx;
            r_out_y     <= r_out_y;
        end else begin
            r_out_valid <= r_out_valid;
            r_out_hit   <= r_out_hit;
            r_out_idx   <= r_out_idx;
            r_out_y     <= r_out_y;
        end
    end

    // Miss counter and its saturation flag, kept registered together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_miss_count <= '0;
            r_miss_sat   <= 1'b0;
        end else begin
            r_miss_count <= w_cnt_nxt;
            r_miss_sat   <= &w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_masked_match_decoder.sv
// Directed bench for masked_match_decoder with a table-scan reference model.
module tb_masked_match_decoder;

    localparam int WIDTH   = 2;
    localparam int ENTRIES = 16;
    localparam int IDXW    = 4;
    localparam int CNTW    = 3;

    logic             clk;
    logic             rst_n;
    logic             cfg_we;
    logic [IDXW-1:0]  cfg_idx;
    logic             cfg_en;
    logic [WIDTH-1:0] cfg_value;
    logic [WIDTH-1:0] cfg_mask;
    logic             cfg_y;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_code;
    logic             out_valid;
    logic             out_ready;
    logic             out_hit;
    logic [IDXW-1:0]  out_idx;
    logic             out_y;
    logic             miss_clr;
    logic [CNTW-1:0]  miss_count;
    logic             miss_sat;

    int n_cmp = 0;
    int n_bad = 0;

    masked_match_decoder #(
        .WIDTH(WIDTH), .ENTRIES(ENTRIES), .CNTW(CNTW), .DEFAULT_Y(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
        .cfg_value(cfg_value), .cfg_mask(cfg_mask), .cfg_y(cfg_y),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_hit(out_hit), .out_idx(out_idx), .out_y(out_y),
        .miss_clr(miss_clr), .miss_count(miss_count), .miss_sat(miss_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: table as plain arrays, output stage as a held record.
    logic             t_en  [ENTRIES];
    logic [WIDTH-1:0] t_val [ENTRIES];
    logic [WIDTH-1:0] t_msk [ENTRIES];
    logic             t_y   [ENTRIES];
    logic             m_valid = 1'b0;
    logic             m_hit = 1'b0;
    int               m_idx = 0;
    logic             m_y = 1'b0;
    int               m_cnt = 0;
    bit               started = 1'b0;

    function automatic int lookup(input logic [WIDTH-1:0] c);
        for (int i = 0; i < ENTRIES; i++) begin
            if (t_en[i] && (((c ^ t_val[i]) & ~t_msk[i]) == 2'b00)) return i;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        bit acc;
        int k;
        started = 1'b1;
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                t_en[i] = 1'b0; t_val[i] = 2'b00; t_msk[i] = 2'b00; t_y[i] = 1'b0;
            end
            m_valid = 1'b0; m_hit = 1'b0; m_idx = 0; m_y = 1'b0; m_cnt = 0;
        end else begin
            acc = in_valid && (!m_valid || out_ready);
            k = lookup(in_code);
            if (miss_clr) m_cnt = 0;
            else if (acc && k < 0 && m_cnt < 7) m_cnt = m_cnt + 1;
            if (acc) begin
                m_valid = 1'b1;
                m_hit   = (k >= 0);
                m_idx   = (k >= 0) ? k : 0;
                m_y     = (k >= 0) ? t_y[k] : 1'b0;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (cfg_we && int'(cfg_idx) < ENTRIES) begin
                t_en[cfg_idx] = cfg_en; t_val[cfg_idx] = cfg_value;
                t_msk[cfg_idx] = cfg_mask; t_y[cfg_idx] = cfg_y;
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model, on the falling edge.
    always @(negedge clk) begin
        if (started) begin
            chk("cmp_in_ready", {31'b0, in_ready}, {31'b0, rst_n && (!m_valid || out_ready)});
            chk("cmp_out_valid", {31'b0, out_valid}, {31'b0, m_valid});
            chk("cmp_out_hit", {31'b0, out_hit}, {31'b0, m_hit});
            chk("cmp_out_idx", {28'b0, out_idx}, m_idx);
            chk("cmp_out_y", {31'b0, out_y}, {31'b0, m_y});
            chk("cmp_miss_count", {29'b0, miss_count}, m_cnt);
            chk("cmp_miss_sat", {31'b0, miss_sat}, {31'b0, m_cnt == 7});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input int idx, input logic en, input logic [1:0] v,
                      input logic [1:0] m, input logic y);
        cfg_idx = IDXW'(idx); cfg_en = en; cfg_value = v; cfg_mask = m; cfg_y = y;
        cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic send(input logic [1:0] c);
        in_valid = 1'b1;
        in_code  = c;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expect_res(input string name, input logic h, input int idx, input logic y);
        chk({name, "_hit"}, {31'b0, out_hit}, {31'b0, h});
        chk({name, "_idx"}, {28'b0, out_idx}, idx);
        chk({name, "_y"}, {31'b0, out_y}, {31'b0, y});
    endtask

    logic [1:0] stream_codes [8];

    initial begin
        stream_codes = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd0, 2'd3, 2'd2};
        rst_n = 1'b0; in_valid = 1'b1; in_code = 2'b01; out_ready = 1'b1;
        miss_clr = 1'b0;
        // A write attempted while in reset must not take effect.
        cfg_we = 1'b1; cfg_idx = 4'd5; cfg_en = 1'b1; cfg_value = 2'b01;
        cfg_mask = 2'b00; cfg_y = 1'b1;
        repeat (3) tick();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_miss_count", {29'b0, miss_count}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        cfg_we = 1'b0;
        rst_n  = 1'b1;
        #1;
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("first_valid", {31'b0, out_valid}, 32'd1);
        expect_res("first_miss", 1'b0, 0, 1'b0);
        chk("first_miss_count", {29'b0, miss_count}, 32'd1);

        wr(0, 1'b1, 2'b00, 2'b00, 1'b0);
        wr(1, 1'b1, 2'b01, 2'b00, 1'b1);
        wr(2, 1'b1, 2'b10, 2'b01, 1'b1);
        send(2'b00); expect_res("map00", 1'b1, 0, 1'b0);
        send(2'b01); expect_res("map01", 1'b1, 1, 1'b1);
        send(2'b10); expect_res("map10", 1'b1, 2, 1'b1);
        send(2'b11); expect_res("map11", 1'b1, 2, 1'b1);
        wr(2, 1'b0, 2'b10, 2'b01, 1'b1);
        send(2'b10); expect_res("dis2", 1'b0, 0, 1'b0);
        chk("dis2_miss_count", {29'b0, miss_count}, 32'd2);

        wr(3, 1'b1, 2'b00, 2'b11, 1'b1);
        send(2'b00); expect_res("prio_e0", 1'b1, 0, 1'b0);
        wr(0, 1'b0, 2'b00, 2'b00, 1'b0);
        send(2'b00); expect_res("prio_e3", 1'b1, 3, 1'b1);

        wr(0, 1'b1, 2'b00, 2'b00, 1'b0);
        wr(2, 1'b1, 2'b10, 2'b00, 1'b0);
        out_ready = 1'b0; in_valid = 1'b1; in_code = 2'b01;
        tick();
        in_code = 2'b11;
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
            expect_res("bp_hold", 1'b1, 1, 1'b1);
        end
        out_ready = 1'b1;
        tick();
        expect_res("bp_release", 1'b1, 3, 1'b1);
        for (int k = 0; k < 8; k++) begin
            in_code = stream_codes[k];
            tick();
            chk("stream_valid", {31'b0, out_valid}, 32'd1);
            chk("stream_idx", {28'b0, out_idx}, {30'b0, stream_codes[k]});
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drain", {31'b0, out_valid}, 32'd0);

        wr(3, 1'b0, 2'b00, 2'b00, 1'b0);
        miss_clr = 1'b1;
        tick();
        miss_clr = 1'b0;
        chk("clr_count", {29'b0, miss_count}, 32'd0);
        in_valid = 1'b1; in_code = 2'b11;
        for (int n = 1; n <= 9; n++) begin
            tick();
            if (n == 6) begin
                chk("sat6_count", {29'b0, miss_count}, 32'd6);
                chk("sat6_flag", {31'b0, miss_sat}, 32'd0);
            end
            if (n == 7) chk("sat7_flag", {31'b0, miss_sat}, 32'd1);
        end
        chk("sat9_count", {29'b0, miss_count}, 32'd7);
        chk("sat9_flag", {31'b0, miss_sat}, 32'd1);
        miss_clr = 1'b1;
        tick();
        miss_clr = 1'b0; in_valid = 1'b0;
        chk("clr_vs_miss_count", {29'b0, miss_count}, 32'd0);
        chk("clr_vs_miss_sat", {31'b0, miss_sat}, 32'd0);

        cfg_idx = 4'd1; cfg_en = 1'b1; cfg_value = 2'b01; cfg_mask = 2'b00; cfg_y = 1'b0;
        cfg_we = 1'b1; in_valid = 1'b1; in_code = 2'b01;
        tick();
        cfg_we = 1'b0;
        expect_res("collide_old", 1'b1, 1, 1'b1);
        tick();
        in_valid = 1'b0;
        expect_res("collide_new", 1'b1, 1, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
